// File: rtl/xc_malu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// micro-op bit positions and the iteration counter width.
package xc_malu_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int UOP_MUL   = 0;
  localparam int UOP_MULU  = 1;
  localparam int UOP_MULSU = 2;
  localparam int UOP_CLMUL = 3;
  localparam int UOP_DIV   = 4;
  localparam int UOP_DIVU  = 5;
  localparam int UOP_REM   = 6;
  localparam int UOP_REMU  = 7;
  localparam int UOP_NUM   = 8;

  // Wide enough to hold XLEN itself, the longest (divide) iteration count.
  function automatic int ctr_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/xc_malu_divstep.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when it fits.
module xc_malu_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            bit_in,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  assign shifted_s = {rem_in, bit_in};
  assign diff_s    = shifted_s - {1'b0, divisor};
  assign q_bit     = (shifted_s >= {1'b0, divisor});
  // The kept value is always below the divisor, so it fits back into XLEN bits.
  assign rem_out   = q_bit ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];

endmodule

// File: rtl/xc_malu_iter.sv
// Iterative multiply/divide unit: magnitude datapath with STEP-bit radix
// multiply, restoring divide, and a registered sign-fixup stage.
module xc_malu_iter
  import xc_malu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              valid,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic              uop_mul,
  input  logic              uop_mulu,
  input  logic              uop_mulsu,
  input  logic              uop_clmul,
  input  logic              uop_div,
  input  logic              uop_divu,
  input  logic              uop_rem,
  input  logic              uop_remu,
  output logic [2*XLEN-1:0] result,
  output logic              ready
);

  localparam int CTR_W = ctr_width(XLEN);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] MUL_LAST = CTR_W'(XLEN / STEP - 1);
  localparam logic [CTR_W-1:0] DIV_LAST = CTR_W'(XLEN - 1);

  logic [UOP_NUM-1:0] uop_s;
  logic               accept_s, is_mul_op_s, a_signed_s, b_signed_s;
  logic               a_neg_s, b_neg_s, neg_s;
  logic [XLEN-1:0]    a_mag_s, b_mag_s;
  logic [2*XLEN-1:0]  pp_s, mul_fix_s, result_nx_s;
  logic [XLEN-1:0]    div_val_s, div_fix_s, rem_nx_s;
  logic               q_bit_s;

  logic [2:0]         state_r;
  logic [CTR_W-1:0]   counter_r;
  logic [2*XLEN-1:0]  acc_r, mcand_r, result_r;
  logic [XLEN-1:0]    mplier_r, dvd_r, dvs_r, rem_r;
  logic               neg_r, is_mul_r, is_clmul_r, sel_rem_r, ready_r;

  assign uop_s = {uop_remu, uop_rem, uop_divu, uop_div,
                  uop_clmul, uop_mulsu, uop_mulu, uop_mul};

  assign accept_s    = valid && !flush && $onehot(uop_s);
  assign is_mul_op_s = uop_s[UOP_MUL] | uop_s[UOP_MULU] | uop_s[UOP_MULSU] | uop_s[UOP_CLMUL];
  assign a_signed_s  = uop_s[UOP_MUL] | uop_s[UOP_MULSU] | uop_s[UOP_DIV] | uop_s[UOP_REM];
  assign b_signed_s  = uop_s[UOP_MUL] | uop_s[UOP_DIV] | uop_s[UOP_REM];
  assign a_neg_s     = a_signed_s & rs1[XLEN-1];
  assign b_neg_s     = b_signed_s & rs2[XLEN-1];
  // A zero divisor yields an all-ones quotient that must not be negated.
  assign neg_s = (uop_s[UOP_MUL] & (a_neg_s ^ b_neg_s))
               | (uop_s[UOP_MULSU] & a_neg_s)
               | (uop_s[UOP_DIV] & (a_neg_s ^ b_neg_s) & (|rs2))
               | (uop_s[UOP_REM] & a_neg_s);

  // Operand magnitudes latched on acceptance.
  always_comb begin
    a_mag_s = rs1;
    b_mag_s = rs2;
    if (a_neg_s) a_mag_s = -rs1;
    else         a_mag_s = rs1;
    if (b_neg_s) b_mag_s = -rs2;
    else         b_mag_s = rs2;
  end

  // Partial product for this cycle's STEP multiplier bits.
  always_comb begin
    pp_s = acc_r;
    for (int j = 0; j < STEP; j++) begin
      if (mplier_r[j]) begin
        if (is_clmul_r) pp_s = pp_s ^ (mcand_r << j);
        else            pp_s = pp_s + (mcand_r << j);
      end else begin
        pp_s = pp_s;
      end
    end
  end

  xc_malu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_in  (rem_r),
    .divisor (dvs_r),
    .bit_in  (dvd_r[XLEN-1]),
    .rem_out (rem_nx_s),
    .q_bit   (q_bit_s)
  );

  // Sign fixup applied in FIX.
  always_comb begin
    mul_fix_s = acc_r;
    div_val_s = dvd_r;
    div_fix_s = dvd_r;
    if (neg_r) mul_fix_s = -acc_r;
    else       mul_fix_s = acc_r;
    if (sel_rem_r) div_val_s = rem_r;
    else           div_val_s = dvd_r;
    if (neg_r) div_fix_s = -div_val_s;
    else       div_fix_s = div_val_s;
    if (is_mul_r) result_nx_s = mul_fix_s;
    else          result_nx_s = {{XLEN{1'b0}}, div_fix_s};
  end

  // Control FSM and iterative datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      counter_r  <= {CTR_W{1'b0}};
      acc_r      <= {(2*XLEN){1'b0}};
      mcand_r    <= {(2*XLEN){1'b0}};
      result_r   <= {(2*XLEN){1'b0}};
      mplier_r   <= {XLEN{1'b0}};
      dvd_r      <= {XLEN{1'b0}};
      dvs_r      <= {XLEN{1'b0}};
      rem_r      <= {XLEN{1'b0}};
      neg_r      <= 1'b0;
      is_mul_r   <= 1'b0;
      is_clmul_r <= 1'b0;
      sel_rem_r  <= 1'b0;
      ready_r    <= 1'b0;
    end else if (flush) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          if (accept_s) begin
            state_r    <= is_mul_op_s ? ST_MUL : ST_DIV;
            counter_r  <= {CTR_W{1'b0}};
            acc_r      <= {(2*XLEN){1'b0}};
            mcand_r    <= {{XLEN{1'b0}}, a_mag_s};
            mplier_r   <= b_mag_s;
            dvd_r      <= a_mag_s;
            dvs_r      <= b_mag_s;
            rem_r      <= {XLEN{1'b0}};
            neg_r      <= neg_s;
            is_mul_r   <= is_mul_op_s;
            is_clmul_r <= uop_s[UOP_CLMUL];
            sel_rem_r  <= uop_s[UOP_REM] | uop_s[UOP_REMU];
          end
        end
        ST_MUL: begin
          if (!valid) begin
            state_r <= ST_IDLE;
          end else begin
            acc_r     <= pp_s;
            mcand_r   <= mcand_r << STEP;
            mplier_r  <= mplier_r >> STEP;
            counter_r <= counter_r + CTR_ONE;
            if (counter_r == MUL_LAST) state_r <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (!valid) begin
            state_r <= ST_IDLE;
          end else begin
            rem_r     <= rem_nx_s;
            dvd_r     <= {dvd_r[XLEN-2:0], q_bit_s};
            counter_r <= counter_r + CTR_ONE;
            if (counter_r == DIV_LAST) state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!valid) begin
            state_r <= ST_IDLE;
          end else begin
            result_r <= result_nx_s;
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign ready  = ready_r;

endmodule

// File: tb/tb_xc_malu_iter.sv
// Randomised bench for xc_malu_iter: STEP=1 and STEP=4 instances run the same
// operations against an arithmetic reference model checked every cycle.
module tb_xc_malu_iter;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic        flush  = 1'b0;
  logic        valid  = 1'b0;
  logic [31:0] rs1    = 32'h0;
  logic [31:0] rs2    = 32'h0;
  logic [7:0]  uop_v  = 8'h0;
  logic [63:0] result1, result4;
  logic        ready1, ready4;

  int          checks   = 0;
  int          failures = 0;
  bit          mon_on   = 1'b0;
  int          cyc      = 0;
  int          lat1     = 0;
  int          lat4     = 0;
  logic [63:0] exp_res  = 64'h0;

  always #5 clock = ~clock;

  xc_malu_iter #(.XLEN(32), .STEP(1)) dut1 (
    .clock(clock), .resetn(resetn), .flush(flush), .valid(valid),
    .rs1(rs1), .rs2(rs2),
    .uop_mul(uop_v[0]), .uop_mulu(uop_v[1]), .uop_mulsu(uop_v[2]), .uop_clmul(uop_v[3]),
    .uop_div(uop_v[4]), .uop_divu(uop_v[5]), .uop_rem(uop_v[6]), .uop_remu(uop_v[7]),
    .result(result1), .ready(ready1)
  );

  xc_malu_iter #(.XLEN(32), .STEP(4)) dut4 (
    .clock(clock), .resetn(resetn), .flush(flush), .valid(valid),
    .rs1(rs1), .rs2(rs2),
    .uop_mul(uop_v[0]), .uop_mulu(uop_v[1]), .uop_mulsu(uop_v[2]), .uop_clmul(uop_v[3]),
    .uop_div(uop_v[4]), .uop_divu(uop_v[5]), .uop_rem(uop_v[6]), .uop_remu(uop_v[7]),
    .result(result4), .ready(ready4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: ops 0..7 = mul, mulu, mulsu, clmul, div, divu, rem, remu.
  function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    int          sa = a;
    int          sb = b;
    int          qr;
    logic [63:0] r = 64'h0;
    bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      0: r = longint'(sa) * longint'(sb);
      1: r = {32'h0, a} * {32'h0, b};
      2: r = longint'(sa) * longint'({32'h0, b});
      3: for (int i = 0; i < 32; i++) if (b[i]) r = r ^ ({32'h0, a} << i);
      4: begin
        if (b == 32'h0) r = {32'h0, 32'hFFFF_FFFF};
        else if (ovf) r = {32'h0, a};
        else begin qr = sa / sb; r = {32'h0, qr}; end
      end
      5: r = (b == 32'h0) ? {32'h0, 32'hFFFF_FFFF} : {32'h0, a / b};
      6: begin
        if (b == 32'h0) r = {32'h0, a};
        else if (ovf) r = 64'h0;
        else begin qr = sa % sb; r = {32'h0, qr}; end
      end
      default: r = (b == 32'h0) ? {32'h0, a} : {32'h0, a % b};
    endcase
    return r;
  endfunction

  // Per-cycle compare of both instances against the expected ready/result.
  always @(negedge clock) begin
    if (mon_on) begin
      chk("ready_step1", 64'(ready1), 64'(cyc >= lat1));
      chk("ready_step4", 64'(ready4), 64'(cyc >= lat4));
      if (cyc >= lat1) chk("result_step1", result1, exp_res);
      if (cyc >= lat4) chk("result_step4", result4, exp_res);
    end
  end

  // pre: 0 none, 1 flush with valid, 2 zero uop, 3 two-hot uop (one cycle before the real op)
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input int pre);
    @(negedge clock);
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
    if (pre != 0) begin
      flush = (pre == 1);
      if (pre == 2)      uop_v = 8'h00;
      else if (pre == 3) uop_v = (8'h01 << op) | (8'h01 << ((op + 1) % 8));
      else               uop_v = 8'h01 << op;
      @(negedge clock);
      flush = 1'b0;
    end
    uop_v   = 8'h01 << op;
    exp_res = expv;
    lat1    = 34;
    lat4    = (op < 4) ? 10 : 34;
    @(posedge clock);
    cyc    = 0;
    mon_on = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      cyc = k;
      #1;
      if (k == 2) begin rs1 = $urandom; rs2 = $urandom; end
      if (k == 37) valid = 1'b0;
    end
    @(negedge clock);
    mon_on = 1'b0;
    flush  = 1'b1;
    uop_v  = 8'h00;
    @(posedge clock);
    #1 flush = 1'b0;
    chk("flush_ready1", 64'(ready1), 64'h0);
    chk("flush_ready4", 64'(ready4), 64'h0);
    chk("flush_hold1", result1, expv);
    chk("flush_hold4", result4, expv);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          op;
    logic [31:0] a, b;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_ready1", 64'(ready1), 64'h0);
    chk("reset_result1", result1, 64'h0);
    chk("reset_ready4", 64'(ready4), 64'h0);
    chk("reset_result4", result4, 64'h0);
    @(negedge clock);
    resetn = 1'b1;

    chk("model_mul",   model(0, 32'hFFFF_FFFF, 32'h3), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_mulu",  model(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("model_clmul", model(3, 32'h3, 32'h3), 64'h5);
    chk("model_rem",   model(6, 32'hFFFF_FFF9, 32'h2), 64'h0000_0000_FFFF_FFFF);

    run_op(0, 32'hFFFF_FFFF, 32'h3,         64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    run_op(3, 32'h3,         32'h3,         64'h5, 0);
    run_op(4, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000, 0);
    run_op(6, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 0);
    run_op(5, 32'h1234_5678, 32'h0,         64'hFFFF_FFFF, 0);
    run_op(7, 32'h1234_5678, 32'h0,         64'h1234_5678, 0);
    run_op(6, 32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF, 0);
    run_op(2, 32'hFFFF_FFFF, 32'h2,         64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op(4, 32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFD, 1);
    run_op(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2);
    run_op(4, 32'h5,         32'h0,         64'hFFFF_FFFF, 3);

    // Valid drop mid-operation aborts; the next op is accepted one cycle later.
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      rs1   = 32'd100;
      rs2   = 32'd7;
      uop_v = (t == 0) ? 8'h10 : 8'h01;
      valid = 1'b1;
      @(posedge clock);
      repeat (5) @(posedge clock);
      #1 valid = 1'b0;
      @(posedge clock);
      #1;
      chk("abort_ready1", 64'(ready1), 64'h0);
      chk("abort_ready4", 64'(ready4), 64'h0);
      run_op(5, 32'd1000, 32'd7, 64'd142, 0);
    end

    // Asynchronous reset mid-multiply clears result and ready at once.
    @(negedge clock);
    rs1   = 32'h1234_5678;
    rs2   = 32'h9;
    uop_v = 8'h01;
    valid = 1'b1;
    @(posedge clock);
    repeat (5) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid_ready1", 64'(ready1), 64'h0);
    chk("rst_mid_result1", result1, 64'h0);
    chk("rst_mid_ready4", 64'(ready4), 64'h0);
    chk("rst_mid_result4", result4, 64'h0);
    @(negedge clock);
    valid  = 1'b0;
    uop_v  = 8'h00;
    resetn = 1'b1;

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7);
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, model(op, a, b), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
